// File: rtl/microseq_pkg.sv
// Shared sequencing opcodes, condition indices and default widths
// for the microprogrammed control unit.
package microseq_pkg;

    localparam int ADDR_W_DEF = 10;

    localparam logic [2:0] NS_INC   = 3'd0;
    localparam logic [2:0] NS_JMP   = 3'd1;
    localparam logic [2:0] NS_DISP  = 3'd2;
    localparam logic [2:0] NS_CJMP  = 3'd3;
    localparam logic [2:0] NS_WAIT  = 3'd4;
    localparam logic [2:0] NS_CALL  = 3'd5;
    localparam logic [2:0] NS_RET   = 3'd6;
    localparam logic [2:0] NS_FETCH = 3'd7;

    localparam int COND_MOC = 0;
    localparam int COND_Z   = 1;
    localparam int COND_N   = 2;
    localparam int COND_C   = 3;

endpackage

// File: rtl/micro_stack.sv
// Return-address LIFO for micro-subroutine calls.
// The count register doubles as the write pointer.
module micro_stack #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW:0]       cnt;
    logic [PW-1:0]     wr_idx;
    logic [PW-1:0]     top_idx;

    assign wr_idx  = cnt[PW-1:0];
    assign top_idx = wr_idx - PW'(1);
    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign dout    = mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= din;
            cnt         <= cnt + 1'b1;
        end else if (pop && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Micro-PC and next-address generator: increment, jump, dispatch,
// conditional branch, wait-on-condition and subroutine call/return.
module microsequencer
    import microseq_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_DEPTH = 4,
    parameter int NCOND       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic [2:0]               ns_sel,
    input  logic [$clog2(NCOND)-1:0] cond_sel,
    input  logic                     cond_inv,
    input  logic [ADDR_W-1:0]        cr_addr,
    input  logic [NCOND-1:0]         cond_vec,
    input  logic [ADDR_W-1:0]        dispatch_addr,
    output logic [ADDR_W-1:0]        next_state,
    output logic                     stack_ovf,
    output logic                     stack_unf
);

    logic              cond;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] nxt;
    logic [ADDR_W-1:0] stk_dout;
    logic              stk_full;
    logic              stk_empty;
    logic              do_call;
    logic              do_ret;

    assign cond    = cond_vec[cond_sel] ^ cond_inv;
    assign inc     = next_state + ADDR_W'(1);
    assign do_call = !stall && (ns_sel == NS_CALL);
    assign do_ret  = !stall && (ns_sel == NS_RET);

    micro_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (ADDR_W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (do_call),
        .pop   (do_ret),
        .din   (inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        nxt = inc;
        case (ns_sel)
            NS_INC:   nxt = inc;
            NS_JMP:   nxt = cr_addr;
            NS_DISP:  nxt = dispatch_addr;
            NS_CJMP:  nxt = cond ? cr_addr : inc;
            NS_WAIT:  nxt = cond ? inc : next_state;
            NS_CALL:  nxt = cr_addr;
            NS_RET:   nxt = stk_empty ? '0 : stk_dout;
            NS_FETCH: nxt = '0;
            default:  nxt = inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_state <= '0;
            stack_ovf  <= 1'b0;
            stack_unf  <= 1'b0;
        end else if (!stall) begin
            next_state <= nxt;
            if (do_call && stk_full)  stack_ovf <= 1'b1;
            if (do_ret  && stk_empty) stack_unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Directed and random checks of the microsequencer against
// a queue-based reference model.
module tb_microsequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic [2:0] ns_sel;
    logic [1:0] cond_sel;
    logic       cond_inv;
    logic [9:0] cr_addr;
    logic [3:0] cond_vec;
    logic [9:0] dispatch_addr;
    logic [9:0] next_state;
    logic       stack_ovf;
    logic       stack_unf;

    int checks = 0;
    int errors = 0;

    int m_upc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    always #5 clk = ~clk;

    microsequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .ns_sel        (ns_sel),
        .cond_sel      (cond_sel),
        .cond_inv      (cond_inv),
        .cr_addr       (cr_addr),
        .cond_vec      (cond_vec),
        .dispatch_addr (dispatch_addr),
        .next_state    (next_state),
        .stack_ovf     (stack_ovf),
        .stack_unf     (stack_unf)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " upc"}, int'(next_state), m_upc);
        chk({tag, " ovf"}, int'(stack_ovf), int'(m_ovf));
        chk({tag, " unf"}, int'(stack_unf), int'(m_unf));
    endtask

    task automatic model_update();
        int inc;
        bit c;
        inc = (m_upc + 1) % 1024;
        c = cond_vec[cond_sel] ^ cond_inv;
        if (reset) begin
            m_upc = 0;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (!stall) begin
            case (ns_sel)
                3'd0: m_upc = inc;
                3'd1: m_upc = cr_addr;
                3'd2: m_upc = dispatch_addr;
                3'd3: m_upc = c ? int'(cr_addr) : inc;
                3'd4: m_upc = c ? inc : m_upc;
                3'd5: begin
                    if (m_stk.size() < 4) m_stk.push_back(inc);
                    else m_ovf = 1;
                    m_upc = cr_addr;
                end
                3'd6: begin
                    if (m_stk.size() > 0) m_upc = m_stk.pop_back();
                    else begin
                        m_upc = 0;
                        m_unf = 1;
                    end
                end
                default: m_upc = 0;
            endcase
        end
    endtask

    task automatic step(input logic [2:0] ns, input logic [9:0] cr,
                        input logic [1:0] cs, input logic ci,
                        input logic [3:0] cv, input logic st,
                        input logic rst);
        ns_sel   = ns;
        cr_addr  = cr;
        cond_sel = cs;
        cond_inv = ci;
        cond_vec = cv;
        stall    = st;
        reset    = rst;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] ns, input logic [9:0] cr);
        step(ns, cr, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        m_upc = 0; m_ovf = 0; m_unf = 0;
        dispatch_addr = 10'h014;
        step(3'd0, 10'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);
        check_all("reset");
        chk("reset const", int'(next_state), 0);

        // 1: increments and reset during CALL
        for (int i = 1; i <= 3; i++) begin
            op(3'd0, 10'h0);
            check_all("inc");
            chk("inc const", int'(next_state), i);
        end
        step(3'd5, 10'h155, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);
        check_all("rst over call");
        op(3'd6, 10'h0);
        check_all("ret after rst");
        chk("unf after rst", int'(stack_unf), 1);
        step(3'd0, 10'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);

        // 2: dispatch and wrap
        op(3'd2, 10'h0);
        chk("disp", int'(next_state), 'h014);
        op(3'd1, 10'h3FF);
        chk("jmp 3ff", int'(next_state), 'h3FF);
        op(3'd0, 10'h0);
        chk("wrap", int'(next_state), 0);
        check_all("wrap model");

        // 3: wait on MOC
        op(3'd1, 10'h02A);
        for (int i = 0; i < 3; i++) begin
            step(3'd4, 10'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
            chk("wait hold", int'(next_state), 'h02A);
        end
        step(3'd4, 10'h0, 2'd0, 1'b0, 4'h1, 1'b0, 1'b0);
        chk("wait go", int'(next_state), 'h02B);

        // 4: conditional jump on Z
        op(3'd1, 10'h030);
        step(3'd3, 10'h041, 2'd1, 1'b0, 4'h2, 1'b0, 1'b0);
        chk("cjmp z1", int'(next_state), 'h041);
        op(3'd1, 10'h030);
        step(3'd3, 10'h041, 2'd1, 1'b0, 4'hD, 1'b0, 1'b0);
        chk("cjmp z0", int'(next_state), 'h031);
        op(3'd1, 10'h030);
        step(3'd3, 10'h041, 2'd1, 1'b1, 4'h0, 1'b0, 1'b0);
        chk("cjmp z0 inv", int'(next_state), 'h041);

        // 5: nested call/return and overflow
        op(3'd1, 10'h050);
        op(3'd5, 10'h100);
        chk("call1", int'(next_state), 'h100);
        op(3'd0, 10'h0);
        op(3'd5, 10'h200);
        chk("call2", int'(next_state), 'h200);
        op(3'd6, 10'h0);
        chk("ret1", int'(next_state), 'h102);
        op(3'd6, 10'h0);
        chk("ret2", int'(next_state), 'h051);
        check_all("ret model");
        for (int i = 0; i < 5; i++) op(3'd5, 10'(10'h300 + i * 16));
        chk("ovf target", int'(next_state), 'h340);
        chk("ovf flag", int'(stack_ovf), 1);
        for (int i = 0; i < 4; i++) begin
            op(3'd6, 10'h0);
            check_all("ovf unwind");
        end

        // 6: underflow and stall
        step(3'd0, 10'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);
        op(3'd1, 10'h077);
        op(3'd6, 10'h0);
        chk("unf upc", int'(next_state), 0);
        chk("unf flag", int'(stack_unf), 1);
        op(3'd0, 10'h0);
        chk("unf sticky", int'(stack_unf), 1);
        op(3'd1, 10'h060);
        op(3'd5, 10'h180);
        step(3'd5, 10'h1C0, 2'd0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("stall hold", int'(next_state), 'h180);
        step(3'd6, 10'h0, 2'd0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("stall ret", int'(next_state), 'h180);
        op(3'd6, 10'h0);
        chk("ret post stall", int'(next_state), 'h061);
        op(3'd6, 10'h0);
        check_all("depth kept");
        op(3'd7, 10'h0);
        check_all("fetch");

        // Random sequencing
        step(3'd0, 10'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            dispatch_addr = 10'($urandom);
            step(3'($urandom), 10'($urandom), 2'($urandom),
                 1'($urandom), 4'($urandom),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 59) == 0));
            check_all("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
